comp_iter: RTL

- Parametrised, multi-cycle successor to the combinational comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, starting at the MSB chunk.
- Produces a 2-bit magnitude result and an RV32 branch-taken flag.
- Uses valid/ready handshakes on input and output; sits between decode/operand fetch and the branch/PC-select logic.

---
 rtl/comp_iter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/comp_iter.sv
// Multi-cycle magnitude comparator with an RV32 branch predicate, CHUNK bits per cycle from the MSB.
// Optional COMP_ITER_EARLY_EXIT_EN: leave RUN as soon as the first differing chunk is seen.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | comparing chunk r_idx of the latched operands
// DONE  | result presented, waiting for out_ready
module comp_iter #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] input_a,
   input  logic [WIDTH-1:0] input_b,
   input  logic             signed_en,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       res,
   output logic             taken
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic [IW-1:0]    r_idx;
   logic [1:0]       r_acc;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [1:0]       r_res;
   logic             r_taken;

   logic             w_sgn;
   logic [WIDTH-1:0] w_msb;
   logic [CHUNK-1:0] w_ca;
   logic [CHUNK-1:0] w_cb;
   logic [1:0]       w_cmp;
   logic [1:0]       w_res;
   logic             w_taken;
   logic             w_last;

   // Signed operands are stored offset-binary so one unsigned chunk compare serves both.
   always_comb begin
      w_sgn = op[2] ? ~op[1] : signed_en;
      w_msb = {w_sgn, {(WIDTH-1){1'b0}}};
      w_ca  = r_a[r_idx*CHUNK +: CHUNK];
      w_cb  = r_b[r_idx*CHUNK +: CHUNK];
      if (w_ca == w_cb)
         w_cmp = 2'b00;
      else if (w_ca < w_cb)
         w_cmp = 2'b01;
      else
         w_cmp = 2'b10;
      w_res = (r_acc != 2'b00) ? r_acc : w_cmp;
      case (r_op)
         3'b000:          w_taken = (w_res == 2'b00);
         3'b001:          w_taken = (w_res != 2'b00);
         3'b100, 3'b110:  w_taken = (w_res == 2'b01);
         3'b101, 3'b111:  w_taken = (w_res != 2'b01);
         default:         w_taken = 1'b0;
      endcase
`ifdef COMP_ITER_EARLY_EXIT_EN
      w_last = (r_idx == '0) || (w_cmp != 2'b00);
`else
      w_last = (r_idx == '0);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_idx       <= '0;
         r_acc       <= 2'b00;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_res       <= 2'b00;
         r_taken     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a        <= input_a ^ w_msb;
                  r_b        <= input_b ^ w_msb;
                  r_op       <= op;
                  r_idx      <= IDX_LAST;
                  r_acc      <= 2'b00;
                  r_in_ready <= 1'b0;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_last) begin
                  r_res       <= w_res;
                  r_taken     <= w_taken;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_acc <= w_res;
                  r_idx <= r_idx - 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_res       <= 2'b00;
                  r_taken     <= 1'b0;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_res       <= 2'b00;
               r_taken     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign res       = r_res;
   assign taken     = r_taken;

endmodule
